// File: rtl/wide_alu_axi_slave.sv
// AXI4 slave fronting a 128-bit add/subtract unit that works one 32-bit limb per cycle.
// Independent write and read engines share one 16-word register map.
module wide_alu_axi_slave #(
  parameter int AXI_ID_WIDTH   = 7,
  parameter int AXI_USER_WIDTH = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [AXI_ID_WIDTH-1:0] aw_id_i,
  input  logic [31:0]             aw_addr_i,
  input  logic [7:0]              aw_len_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [31:0]             w_data_i,
  input  logic [3:0]              w_strb_i,
  input  logic                    w_last_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  output logic [AXI_ID_WIDTH-1:0] b_id_o,
  output logic [1:0]              b_resp_o,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  input  logic [AXI_ID_WIDTH-1:0] ar_id_i,
  input  logic [31:0]             ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  output logic [AXI_ID_WIDTH-1:0] r_id_o,
  output logic [31:0]             r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic                    busy_o
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t    w_state;
  r_state_t    r_state;
  logic [31:0] op_a [4];
  logic [31:0] op_b [4];
  logic [31:0] res  [4];
  logic [3:0]  wr_idx, rd_idx, rd_sel;
  logic        wr_err;
  logic [7:0]  rd_len, rd_cnt;
  logic        start_q, busy_q, op_sub, cy;
  logic [2:0]  limb;
  logic        alu_active, calc_en, start_req, cout;
  logic [31:0] sum, b_limb, rd_word;
  logic        wr_ok, wr_op, wr_ctrl, rd_err;

  // Bus-compatibility leftovers: address bits outside [5:2], write burst length, user width.
  logic [AXI_USER_WIDTH-1:0] unused_user;
  logic                      unused_ok;
  assign unused_user = '0;
  assign unused_ok   = ^{aw_addr_i[31:6], aw_addr_i[1:0], ar_addr_i[31:6], ar_addr_i[1:0],
                         aw_len_i, unused_user};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) old[8*b +: 8] = data[8*b +: 8];
    return old;
  endfunction

  // A start is pending (start_q) for one cycle before busy rises; both lock the operands.
  assign alu_active = start_q | busy_q;
  assign busy_o     = busy_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ok   = 1'b0;
    wr_op   = 1'b0;
    wr_ctrl = 1'b0;
    unique case (wr_idx[3:2])
      2'b00, 2'b01: begin wr_op = !alu_active; wr_ok = !alu_active; end
      2'b10:        wr_ok = 1'b0;
      default:      begin wr_ctrl = (wr_idx[1:0] == 2'd0); wr_ok = wr_ctrl; end
    endcase
  end

  assign start_req = (w_state == W_DATA) && w_valid_i && wr_ctrl && w_strb_i[0] &&
                     w_data_i[1] && !alu_active;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      w_state    <= W_IDLE;
      aw_ready_o <= 1'b0;
      w_ready_o  <= 1'b0;
      b_valid_o  <= 1'b0;
      b_id_o     <= '0;
      b_resp_o   <= RESP_OKAY;
      wr_idx     <= '0;
      wr_err     <= 1'b0;
      // NOTE: the operand file is only eight words and must read zero after reset, so it is reset.
      for (int i = 0; i < 4; i++) begin
        op_a[i] <= '0;
        op_b[i] <= '0;
      end
    end else begin
      unique case (w_state)
        W_IDLE: begin
          aw_ready_o <= 1'b1;
          if (aw_valid_i && aw_ready_o) begin
            aw_ready_o <= 1'b0;
            w_ready_o  <= 1'b1;
            wr_idx     <= aw_addr_i[5:2];
            b_id_o     <= aw_id_i;
            wr_err     <= 1'b0;
            w_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_valid_i) begin
            if (wr_op && !wr_idx[2]) op_a[wr_idx[1:0]] <= merge(op_a[wr_idx[1:0]], w_data_i, w_strb_i);
            if (wr_op &&  wr_idx[2]) op_b[wr_idx[1:0]] <= merge(op_b[wr_idx[1:0]], w_data_i, w_strb_i);
            if (!wr_ok) wr_err <= 1'b1;
            wr_idx <= wr_idx + 4'd1;
            if (w_last_i) begin
              w_ready_o <= 1'b0;
              b_valid_o <= 1'b1;
              b_resp_o  <= (wr_err || !wr_ok) ? RESP_SLVERR : RESP_OKAY;
              w_state   <= W_RESP;
            end
          end
        end
        default: begin
          if (b_ready_i) begin
            b_valid_o  <= 1'b0;
            aw_ready_o <= 1'b1;
            w_state    <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Subtraction is A + ~B + 1, so the chain starts at op_sub and the borrow is the inverted carry.
  assign b_limb      = op_sub ? ~op_b[limb[1:0]] : op_b[limb[1:0]];
  assign {cout, sum} = {1'b0, op_a[limb[1:0]]} + {1'b0, b_limb} + {32'd0, cy};
  assign calc_en     = start_q || (busy_q && limb != 3'd4);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      op_sub  <= 1'b0;
      cy      <= 1'b0;
      limb    <= '0;
      for (int i = 0; i < 4; i++) res[i] <= '0;
    end else begin
      if (start_req) begin
        start_q <= 1'b1;
        op_sub  <= w_data_i[0];
        cy      <= w_data_i[0];
      end
      if (start_q) begin
        start_q <= 1'b0;
        busy_q  <= 1'b1;
      end
      if (calc_en) begin
        res[limb[1:0]] <= sum;
        cy             <= cout;
        limb           <= limb + 3'd1;
      end
      if (busy_q && limb == 3'd4) begin
        busy_q <= 1'b0;
        limb   <= '0;
      end
    end
  end

  assign rd_sel = (r_state == R_IDLE) ? ar_addr_i[5:2] : rd_idx + 4'd1;

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    unique case (rd_sel[3:2])
      2'b00: rd_word = op_a[rd_sel[1:0]];
      2'b01: rd_word = op_b[rd_sel[1:0]];
      2'b10: rd_word = res[rd_sel[1:0]];
      default: begin
        if (rd_sel[1:0] == 2'd1) rd_word = {30'd0, op_sub ^ cy, busy_q};
        else if (rd_sel[1]) rd_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= R_IDLE;
      ar_ready_o <= 1'b0;
      r_valid_o  <= 1'b0;
      r_id_o     <= '0;
      r_data_o   <= '0;
      r_resp_o   <= RESP_OKAY;
      r_last_o   <= 1'b0;
      rd_idx     <= '0;
      rd_len     <= '0;
      rd_cnt     <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          ar_ready_o <= 1'b1;
          if (ar_valid_i && ar_ready_o) begin
            ar_ready_o <= 1'b0;
            r_valid_o  <= 1'b1;
            r_id_o     <= ar_id_i;
            r_data_o   <= rd_word;
            r_resp_o   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            r_last_o   <= (ar_len_i == 8'd0);
            rd_idx     <= ar_addr_i[5:2];
            rd_len     <= ar_len_i;
            rd_cnt     <= '0;
            r_state    <= R_DATA;
          end
        end
        default: begin
          if (r_ready_i) begin
            if (r_last_o) begin
              r_valid_o  <= 1'b0;
              r_last_o   <= 1'b0;
              ar_ready_o <= 1'b1;
              r_state    <= R_IDLE;
            end else begin
              rd_idx   <= rd_idx + 4'd1;
              rd_cnt   <= rd_cnt + 8'd1;
              r_data_o <= rd_word;
              r_resp_o <= rd_err ? RESP_SLVERR : RESP_OKAY;
              r_last_o <= (rd_cnt + 8'd1 == rd_len);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_alu_axi_slave.sv
// Directed bench for wide_alu_axi_slave: tasks queue expected B/R responses, a negedge
// monitor pops and compares them as the DUT hands them over.
module tb_wide_alu_axi_slave;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [6:0]  aw_id_i = '0, ar_id_i = '0, b_id_o, r_id_o;
  logic [31:0] aw_addr_i = '0, ar_addr_i = '0, w_data_i = '0, r_data_o;
  logic [7:0]  aw_len_i = '0, ar_len_i = '0;
  logic [3:0]  w_strb_i = '0;
  logic        aw_valid_i = 1'b0, aw_ready_o, w_last_i = 1'b0, w_valid_i = 1'b0, w_ready_o;
  logic [1:0]  b_resp_o, r_resp_o;
  logic        b_valid_o, b_ready_i = 1'b1, ar_valid_i = 1'b0, ar_ready_o;
  logic        r_last_o, r_valid_o, r_ready_i = 1'b1, busy_o;

  wide_alu_axi_slave #(.AXI_ID_WIDTH(7), .AXI_USER_WIDTH(6)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [6:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [6:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      b_q[$];
  r_exp_t      r_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] wdata [16];
  logic [3:0]  wstrb [16];
  logic [31:0] rdata [16];
  logic [1:0]  rresp [16];
  int          busy_run = 0;
  int          last_busy = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks R stability under stall.
  b_exp_t      be;
  r_exp_t      re;
  logic        r_stalled = 1'b0;
  logic [41:0] r_held;
  always @(negedge clk_i) begin
    if (b_valid_o && b_ready_i) begin
      if (b_q.size() == 0) check("b_unexpected", b_valid_o, 1'b0);
      else begin
        be = b_q.pop_front();
        check("b_id_resp", {b_id_o, b_resp_o}, be);
      end
    end
    if (r_stalled) check("r_stable", {r_id_o, r_data_o, r_resp_o, r_last_o, r_valid_o}, {r_held, 1'b1});
    if (r_valid_o && r_ready_i) begin
      if (r_q.size() == 0) check("r_unexpected", r_valid_o, 1'b0);
      else begin
        re = r_q.pop_front();
        check("r_beat", {r_id_o, r_data_o, r_resp_o, r_last_o}, re);
      end
    end
    r_stalled = r_valid_o && !r_ready_i;
    r_held    = {r_id_o, r_data_o, r_resp_o, r_last_o};
    if (busy_o) busy_run++;
    else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
  end

  // All tasks start and end #1 after a rising edge.
  task automatic do_write(input logic [31:0] addr, input int n, input logic [6:0] tid,
                          input logic [1:0] resp);
    int t;
    b_q.push_back('{id: tid, resp: resp});
    aw_id_i = tid; aw_addr_i = addr; aw_len_i = 8'(n - 1); aw_valid_i = 1'b1;
    t = 0;
    while (!aw_ready_o && t < 50) begin @(posedge clk_i); #1; t++; end
    if (t >= 50) check("aw_timeout", aw_ready_o, 1'b1);
    @(posedge clk_i); #1;
    aw_valid_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      w_data_i = wdata[i]; w_strb_i = wstrb[i]; w_last_i = (i == n - 1); w_valid_i = 1'b1;
      t = 0;
      while (!w_ready_o && t < 50) begin @(posedge clk_i); #1; t++; end
      if (t >= 50) check("w_timeout", w_ready_o, 1'b1);
      @(posedge clk_i); #1;
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
    t = 0;
    while (b_q.size() != 0 && t < 50) begin @(posedge clk_i); #1; t++; end
    if (b_q.size() != 0) begin
      check("b_timeout", b_q.size(), 0);
      b_q.delete();
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int n, input logic [6:0] tid,
                         input bit toggle);
    int t;
    for (int i = 0; i < n; i++) r_q.push_back('{id: tid, data: rdata[i], resp: rresp[i], last: (i == n - 1)});
    ar_id_i = tid; ar_addr_i = addr; ar_len_i = 8'(n - 1); ar_valid_i = 1'b1;
    t = 0;
    while (!ar_ready_o && t < 50) begin @(posedge clk_i); #1; t++; end
    if (t >= 50) check("ar_timeout", ar_ready_o, 1'b1);
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
    t = 0;
    while (r_q.size() != 0 && t < 200) begin
      r_ready_i = toggle ? ~r_ready_i : 1'b1;
      @(posedge clk_i); #1; t++;
    end
    r_ready_i = 1'b1;
    if (r_q.size() != 0) begin
      check("r_timeout", r_q.size(), 0);
      r_q.delete();
    end
  endtask

  task automatic write1(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input logic [1:0] resp);
    wdata[0] = data; wstrb[0] = strb;
    do_write(addr, 1, 7'h21, resp);
  endtask

  task automatic read1(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    rdata[0] = data; rresp[0] = resp;
    do_read(addr, 1, 7'h33, 1'b0);
  endtask

  task automatic read4(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3);
    rdata[0] = d0; rdata[1] = d1; rdata[2] = d2; rdata[3] = d3;
    for (int i = 0; i < 4; i++) rresp[i] = OKAY;
    do_read(addr, 4, 7'h44, 1'b0);
  endtask

  task automatic read_all_zero(input logic [6:0] tid);
    for (int i = 0; i < 16; i++) begin
      rdata[i] = '0;
      rresp[i] = (i >= 14) ? SLVERR : OKAY;
    end
    do_read(32'h0, 16, tid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_aw_ready", aw_ready_o, 1'b0);
    check("rst_ar_ready", ar_ready_o, 1'b0);
    check("rst_b_valid", b_valid_o, 1'b0);
    check("rst_r_valid", r_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    rst_ni = 1'b1;
    #2;
    check("aw_ready_before_edge", aw_ready_o, 1'b0);
    @(posedge clk_i); #1;
    check("aw_ready_first_edge", aw_ready_o, 1'b1);
    check("ar_ready_first_edge", ar_ready_o, 1'b1);
    read_all_zero(7'h11);

    // 0xFFFF..FF + 1 wraps to 0 with carry out.
    for (int i = 0; i < 4; i++) write1(32'(4 * i), 32'hFFFF_FFFF, 4'hF, OKAY);
    write1(32'h10, 32'h1, 4'hF, OKAY);
    last_busy = 0;
    write1(32'h30, 32'h2, 4'hF, OKAY);
    repeat (6) @(posedge clk_i);
    #1;
    read4(32'h20, 32'h0, 32'h0, 32'h0, 32'h0);
    read1(32'h34, 32'h2, OKAY);
    read1(32'h30, 32'h0, OKAY);
    check("add_busy_cycles", last_busy, 4);

    // 0 - 1 borrows through every limb.
    for (int i = 0; i < 4; i++) begin wdata[i] = '0; wstrb[i] = 4'hF; end
    do_write(32'h00, 4, 7'h22, OKAY);
    last_busy = 0;
    write1(32'h30, 32'h3, 4'hF, OKAY);
    repeat (6) @(posedge clk_i);
    #1;
    read4(32'h20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    read1(32'h34, 32'h2, OKAY);
    check("sub_busy_cycles", last_busy, 4);

    // 0 + 1 with an OP_B write landing while busy.
    write1(32'h30, 32'h2, 4'hF, OKAY);
    write1(32'h14, 32'hDEAD_BEEF, 4'hF, SLVERR);
    repeat (6) @(posedge clk_i);
    #1;
    read4(32'h10, 32'h1, 32'h0, 32'h0, 32'h0);
    read4(32'h20, 32'h1, 32'h0, 32'h0, 32'h0);
    read1(32'h34, 32'h0, OKAY);
    write1(32'h00, 32'h1234_5678, 4'hF, OKAY);
    write1(32'h00, 32'h0000_00AA, 4'h1, OKAY);
    read1(32'h00, 32'h1234_56AA, OKAY);
    write1(32'h20, 32'h5555_5555, 4'hF, SLVERR);
    read1(32'h20, 32'h1, OKAY);
    read1(32'h3C, 32'h0, SLVERR);

    // Burst from 0x38 wraps to 0x00/0x04; the first two beats are dropped.
    wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222;
    wdata[2] = 32'h3333_3333; wdata[3] = 32'h4444_4444;
    for (int i = 0; i < 4; i++) wstrb[i] = 4'hF;
    do_write(32'h38, 4, 7'h23, SLVERR);
    rdata[0] = 32'h3333_3333; rdata[1] = 32'h4444_4444; rresp[0] = OKAY; rresp[1] = OKAY;
    do_read(32'h00, 2, 7'h24, 1'b0);

    // Full-map 16-beat read with r_ready toggling every cycle.
    for (int i = 0; i < 16; i++) begin rdata[i] = '0; rresp[i] = (i >= 14) ? SLVERR : OKAY; end
    rdata[0] = 32'h3333_3333; rdata[1] = 32'h4444_4444; rdata[4] = 32'h1; rdata[8] = 32'h1;
    do_read(32'h00, 16, 7'h5A, 1'b1);

    // Reset during the third beat of a 4-beat write aborts it silently.
    aw_id_i = 7'h25; aw_addr_i = 32'h10; aw_len_i = 8'd3; aw_valid_i = 1'b1;
    @(posedge clk_i); #1;
    aw_valid_i = 1'b0;
    w_data_i = 32'hA5A5_A5A5; w_strb_i = 4'hF; w_last_i = 1'b0; w_valid_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("abort_w_ready_beat3", w_ready_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("abort_aw_ready_in_reset", aw_ready_o, 1'b0);
    w_valid_i = 1'b0;
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("abort_no_b_valid", b_valid_o, 1'b0);
    end
    read_all_zero(7'h12);
    write1(32'h10, 32'hCAFE_F00D, 4'hF, OKAY);
    read1(32'h10, 32'hCAFE_F00D, OKAY);

    repeat (4) @(posedge clk_i);
    #1;
    check("scoreboard_drained", b_q.size() + r_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
